// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the ibus/dbus memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} arb_state_t;

  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Instruction fetches are always 32-bit reads on the shared port.
  function automatic dbus_req_t map_ireq(ibus_req_t r);
    dbus_req_t m;
    m        = '0;
    m.valid  = r.valid;
    m.addr   = r.addr;
    m.size   = MSIZE4;
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of requester and downstream buses around the arbiter
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  modport slave  (input ireq, dreq, mresp, output iresp, dresp, mreq);
  modport master (output ireq, dreq, mresp, input iresp, dresp, mreq);

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one dbus memory port between fetch (ibus) and memory stage (dbus)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_IWAIT = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] i_grants,
  output logic [CNT_W-1:0] d_grants
);

  localparam int IW_W = $clog2(MAX_IWAIT + 1);

  arb_state_t      state;
  logic [IW_W-1:0] iwait;
  dbus_req_t       lat_req;
  dbus_req_t       i_map;
  dbus_req_t       mreq_c;
  ibus_resp_t      iresp_c;
  dbus_resp_t      dresp_c;
  logic            pick_i;
  logic            pick_d;
  logic            addr2;

  assign i_map     = map_ireq(bus.ireq);
  assign bus.mreq  = mreq_c;
  assign bus.iresp = iresp_c;
  assign bus.dresp = dresp_c;

  always_comb begin
    pick_d  = (state == IDLE) && bus.dreq.valid &&
              !(bus.ireq.valid && iwait == IW_W'(MAX_IWAIT));
    pick_i  = (state == IDLE) && bus.ireq.valid && !pick_d;
    addr2   = (state == OWN_I) ? lat_req.addr[2] : bus.ireq.addr[2];
    mreq_c  = '0;
    iresp_c = '0;
    dresp_c = '0;
    // Outputs are forced quiet while reset is asserted; an owner that drops
    // valid early keeps the port driven with the request captured at grant.
    if (!reset) begin
      if (pick_i || state == OWN_I) begin
        mreq_c          = bus.ireq.valid ? i_map : lat_req;
        iresp_c.addr_ok = bus.mresp.addr_ok;
        iresp_c.data_ok = bus.mresp.data_ok;
        iresp_c.data    = addr2 ? bus.mresp.data[63:32] : bus.mresp.data[31:0];
      end else if (pick_d || state == OWN_D) begin
        mreq_c  = bus.dreq.valid ? bus.dreq : lat_req;
        dresp_c = bus.mresp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iwait    <= '0;
      lat_req  <= '0;
      i_grants <= '0;
      d_grants <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            lat_req <= bus.dreq;
            if (bus.ireq.valid && iwait != IW_W'(MAX_IWAIT))
              iwait <= iwait + IW_W'(1);
            if (bus.mresp.data_ok) d_grants <= d_grants + CNT_W'(1);
            else                   state    <= OWN_D;
          end else if (pick_i) begin
            lat_req <= i_map;
            iwait   <= '0;
            if (bus.mresp.data_ok) i_grants <= i_grants + CNT_W'(1);
            else                   state    <= OWN_I;
          end
        end
        OWN_I: begin
          if (bus.mresp.data_ok) begin
            state    <= IDLE;
            i_grants <= i_grants + CNT_W'(1);
          end
        end
        OWN_D: begin
          if (bus.mresp.data_ok) begin
            state    <= IDLE;
            d_grants <= d_grants + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] i_grants;
  logic [3:0] d_grants;
  int         errors;
  int         checks;
  int         exp_i;
  int         exp_d;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_IWAIT(4), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .i_grants (i_grants),
    .d_grants (d_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ireq  = '0;
    bus.dreq  = '0;
    bus.mresp = '0;
  endtask

  task automatic set_i(input logic [63:0] a);
    bus.ireq       = '0;
    bus.ireq.valid = 1'b1;
    bus.ireq.addr  = a;
  endtask

  task automatic set_d(input logic [63:0] a);
    bus.dreq        = '0;
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = a;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = 8'hFF;
    bus.dreq.data   = 64'hA5A5_0000_5A5A_FFFF;
  endtask

  task automatic set_resp(input logic ok, input logic [63:0] d);
    bus.mresp         = '0;
    bus.mresp.addr_ok = ok;
    bus.mresp.data_ok = ok;
    bus.mresp.data    = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    set_i(64'h8000_0000);
    set_resp(1'b1, 64'h1234_5678_9ABC_DEF0);
    #1;
    checks++; if (bus.mreq.valid !== 1'b0) begin errors++; $display("FAIL reset_mreq_valid got=%b want=0", bus.mreq.valid); end
    checks++; if (bus.iresp !== '0) begin errors++; $display("FAIL reset_iresp got=%h want=0", bus.iresp); end
    checks++; if (bus.dresp !== '0) begin errors++; $display("FAIL reset_dresp got=%h want=0", bus.dresp); end
    cyc();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (i_grants !== 4'd0 || d_grants !== 4'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", i_grants, d_grants); end
    checks++; if (bus.mreq.valid !== 1'b0) begin errors++; $display("FAIL idle_mreq_valid got=%b want=0", bus.mreq.valid); end
    exp_i = 0;
    exp_d = 0;
  endtask

  task automatic test_i_only();
    cyc();
    set_i(64'h8000_0004);
    #1;
    checks++; if (bus.mreq.valid !== 1'b1 || bus.mreq.addr !== 64'h8000_0004) begin errors++; $display("FAIL i_fwd_addr got=%b/%h want=1/8000_0004", bus.mreq.valid, bus.mreq.addr); end
    checks++; if (bus.mreq.size !== MSIZE4 || bus.mreq.strobe !== 8'h00) begin errors++; $display("FAIL i_fwd_size got=%0d/%h want=2/00", bus.mreq.size, bus.mreq.strobe); end
    cyc();
    cyc();
    cyc();
    set_resp(1'b1, 64'h1111_2222_3333_4444);
    #1;
    checks++; if (bus.iresp.data_ok !== 1'b1 || bus.iresp.data !== 32'h1111_2222) begin errors++; $display("FAIL i_resp_data got=%b/%h want=1/11112222", bus.iresp.data_ok, bus.iresp.data); end
    checks++; if (bus.dresp !== '0) begin errors++; $display("FAIL i_dresp_zero got=%h want=0", bus.dresp); end
    cyc();
    idle_inputs();
    exp_i++;
    #1;
    checks++; if (i_grants !== 4'(exp_i)) begin errors++; $display("FAIL i_grants got=%0d want=%0d", i_grants, exp_i); end
  endtask

  task automatic test_both();
    cyc();
    set_i(64'h8000_0008);
    set_d(64'h8000_1000);
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_1000 || bus.mreq.strobe !== 8'hFF) begin errors++; $display("FAIL both_d_first got=%h/%h want=80001000/ff", bus.mreq.addr, bus.mreq.strobe); end
    cyc();
    set_resp(1'b1, 64'hCAFE_F00D_0BAD_BEEF);
    #1;
    checks++; if (bus.dresp.data_ok !== 1'b1 || bus.dresp.data !== 64'hCAFE_F00D_0BAD_BEEF) begin errors++; $display("FAIL both_dresp got=%b/%h want=1/cafef00d0badbeef", bus.dresp.data_ok, bus.dresp.data); end
    checks++; if (bus.iresp !== '0) begin errors++; $display("FAIL both_iresp_zero got=%h want=0", bus.iresp); end
    cyc();
    bus.dreq = '0;
    bus.mresp = '0;
    exp_d++;
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_0008 || bus.mreq.size !== MSIZE4) begin errors++; $display("FAIL both_i_next got=%h want=80000008", bus.mreq.addr); end
    cyc();
    set_resp(1'b1, 64'h1111_2222_3333_4444);
    #1;
    checks++; if (bus.iresp.data !== 32'h3333_4444) begin errors++; $display("FAIL both_i_low_word got=%h want=33334444", bus.iresp.data); end
    cyc();
    idle_inputs();
    exp_i++;
    #1;
    checks++; if (i_grants !== 4'(exp_i) || d_grants !== 4'(exp_d)) begin errors++; $display("FAIL both_counts got=%0d/%0d want=%0d/%0d", i_grants, d_grants, exp_i, exp_d); end
  endtask

  task automatic test_starvation();
    logic [63:0] a;
    cyc();
    set_i(64'h8000_0010);
    for (int k = 0; k < 4; k++) begin
      a = 64'h8000_2000 + 64'(k * 8);
      set_d(a);
      bus.mresp = '0;
      #1;
      checks++; if (bus.mreq.addr !== a) begin errors++; $display("FAIL starve_d%0d got=%h want=%h", k, bus.mreq.addr, a); end
      cyc();
      set_resp(1'b1, 64'h0);
      cyc();
      exp_d++;
    end
    set_d(64'h8000_2020);
    bus.mresp = '0;
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_0010) begin errors++; $display("FAIL starve_i_wins got=%h want=80000010", bus.mreq.addr); end
    cyc();
    set_resp(1'b1, 64'h0);
    #1;
    checks++; if (bus.iresp.data_ok !== 1'b1) begin errors++; $display("FAIL starve_i_done got=%b want=1", bus.iresp.data_ok); end
    cyc();
    exp_i++;
    bus.ireq = '0;
    bus.mresp = '0;
    cyc();
    set_resp(1'b1, 64'h0);
    cyc();
    exp_d++;
    set_i(64'h8000_0018);
    set_d(64'h8000_3000);
    bus.mresp = '0;
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_3000) begin errors++; $display("FAIL starve_iwait_cleared got=%h want=80003000", bus.mreq.addr); end
    cyc();
    set_resp(1'b1, 64'h0);
    cyc();
    exp_d++;
    idle_inputs();
  endtask

  task automatic test_protocol_error();
    cyc();
    set_d(64'h8000_4000);
    cyc();
    bus.dreq = '0;
    #1;
    checks++; if (bus.mreq.valid !== 1'b1 || bus.mreq.addr !== 64'h8000_4000 || bus.mreq.strobe !== 8'hFF) begin errors++; $display("FAIL proto_latched got=%b/%h/%h want=1/80004000/ff", bus.mreq.valid, bus.mreq.addr, bus.mreq.strobe); end
    cyc();
    set_resp(1'b1, 64'h77);
    #1;
    checks++; if (bus.dresp.data_ok !== 1'b1) begin errors++; $display("FAIL proto_done got=%b want=1", bus.dresp.data_ok); end
    cyc();
    idle_inputs();
    exp_d++;
  endtask

  task automatic test_zero_wait();
    cyc();
    set_d(64'h8000_5000);
    set_resp(1'b1, 64'h55);
    #1;
    checks++; if (bus.dresp.data_ok !== 1'b1 || bus.mreq.valid !== 1'b1) begin errors++; $display("FAIL zw_same_cycle got=%b/%b want=1/1", bus.dresp.data_ok, bus.mreq.valid); end
    cyc();
    exp_d++;
    set_d(64'h8000_5008);
    bus.mresp = '0;
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_5008 || bus.mreq.valid !== 1'b1) begin errors++; $display("FAIL zw_next_grant got=%h want=80005008", bus.mreq.addr); end
    checks++; if (d_grants !== 4'(exp_d)) begin errors++; $display("FAIL zw_count got=%0d want=%0d", d_grants, exp_d); end
    cyc();
    set_resp(1'b1, 64'h0);
    cyc();
    exp_d++;
    idle_inputs();
    #1;
    checks++; if (d_grants !== 4'(exp_d)) begin errors++; $display("FAIL zw_count2 got=%0d want=%0d", d_grants, exp_d); end
  endtask

  task automatic test_reset_mid();
    cyc();
    set_d(64'h8000_6000);
    #1;
    checks++; if (bus.mreq.valid !== 1'b1) begin errors++; $display("FAIL rm_grant got=%b want=1", bus.mreq.valid); end
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (bus.mreq.valid !== 1'b0 || bus.dresp !== '0) begin errors++; $display("FAIL rm_gated got=%b/%h want=0/0", bus.mreq.valid, bus.dresp); end
    cyc();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.mreq.valid !== 1'b0) begin errors++; $display("FAIL rm_idle got=%b want=0", bus.mreq.valid); end
    checks++; if (i_grants !== 4'd0 || d_grants !== 4'd0) begin errors++; $display("FAIL rm_counters got=%0d/%0d want=0/0", i_grants, d_grants); end
    set_i(64'h8000_7000);
    #1;
    checks++; if (bus.mreq.addr !== 64'h8000_7000 || bus.mreq.valid !== 1'b1) begin errors++; $display("FAIL rm_regrant got=%h want=80007000", bus.mreq.addr); end
    cyc();
    set_resp(1'b1, 64'h0);
    cyc();
    idle_inputs();
    exp_i = 1;
    exp_d = 0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) begin
      cyc();
      set_d(64'h8000_8000 + 64'(k * 8));
      set_resp(1'b1, 64'h0);
      if (k == 15) begin
        #1;
        checks++; if (d_grants !== 4'd15) begin errors++; $display("FAIL wrap_pre got=%0d want=15", d_grants); end
      end
    end
    cyc();
    idle_inputs();
    #1;
    checks++; if (d_grants !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d want=0", d_grants); end
    checks++; if (i_grants !== 4'(exp_i)) begin errors++; $display("FAIL wrap_i_untouched got=%0d want=%0d", i_grants, exp_i); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_i  = 0;
    exp_d  = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_i_only();
    test_both();
    test_starvation();
    test_protocol_error();
    test_zero_wait();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
